// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the LEGv8 pipeline stall/flush controller.
// Contents: controller FSM state type, the zero-register index and default widths.
package pipe_ctrl_pkg;

  localparam int unsigned DefRegW    = 5;
  localparam int unsigned DefCntW    = 32;
  localparam int unsigned DefWaitW   = 4;
  localparam int unsigned DefMaxWait = 15;

  // X31 reads as zero, so a load targeting it never creates a real dependency.
  localparam int unsigned XZR = 31;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   idex_memread  - EX instruction is a load
//   idex_rd       - EX destination register
//   ifid_rn       - ID first source register
//   ifid_rm       - ID second source register
//   ifid_use_rm   - ID instruction actually reads ifid_rm
//   load_use      - ID needs the EX load result; one bubble is required
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = DefRegW
) (
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rn,
  input  logic [REG_W-1:0] ifid_rm,
  input  logic             ifid_use_rm,
  output logic             load_use
);

  logic rd_is_zr;
  logic rn_match;
  logic rm_match;

  assign rd_is_zr = (idex_rd == REG_W'(XZR));
  assign rn_match = (idex_rd == ifid_rn);
  assign rm_match = ifid_use_rm & (idex_rd == ifid_rm);
  assign load_use = idex_memread & ~rd_is_zr & (rn_match | rm_match);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard and stall controller for the 5-stage LEGv8 pipeline.
// Drives enable / synchronous-clear of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   start                      - leave IDLE
//   idex_*, ifid_*             - operands for load-use detection
//   br_taken_mem               - branch in MEM resolved taken
//   dmem_req, dmem_ready       - data memory handshake for the MEM instruction
//   *_en, *_flush              - register enables / bubble inserts (Mealy)
//   stall_cnt, flush_cnt       - saturating performance counters
//   mem_timeout                - sticky: a memory wait lasted MAX_WAIT cycles
//   state_o                    - current FSM state
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W    = DefRegW,
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned WAIT_W   = DefWaitW,
  parameter int unsigned MAX_WAIT = DefMaxWait
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rn,
  input  logic [REG_W-1:0] ifid_rm,
  input  logic             ifid_use_rm,
  input  logic             br_taken_mem,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout,
  output logic [1:0]       state_o
);

  ctrl_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic load_use;
  logic advance;  // pipe is free to move this cycle; apply branch/load-use priorities
  logic stall_cycle;
  logic flush_evt;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .ifid_rn      (ifid_rn),
    .ifid_rm      (ifid_rm),
    .ifid_use_rm  (ifid_use_rm),
    .load_use     (load_use)
  );

  always_comb begin
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    idex_en       = 1'b0;
    exmem_en      = 1'b0;
    memwb_en      = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    advance       = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;

    unique case (state_q)
      IDLE: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          advance = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          if (wait_cnt_q < WAIT_W'(MAX_WAIT)) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
          // Release cycle: a branch frozen in EX/MEM is acted on now.
          state_d    = RUN;
          wait_cnt_d = '0;
          advance    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (br_taken_mem) begin
        // ID instruction is squashed, so its load-use match is irrelevant.
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end

    if (state_d == MEM_WAIT && wait_cnt_d == WAIT_W'(MAX_WAIT)) mem_timeout_d = 1'b1;

    stall_cycle = (state_q != IDLE) && !pc_en;
    flush_evt   = advance && br_taken_mem;

    stall_cnt_d = stall_cnt_q;
    if (stall_cycle && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (flush_evt && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign mem_timeout = mem_timeout_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: the driver pushes the expected outputs for each
// cycle it drives; a negedge monitor pops and compares against the DUT.
module tb_pipe_stall_ctrl;

  localparam logic [4:0] EN_ALL  = 5'b11111;
  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [4:0] EN_LU   = 5'b00111;  // {pc, ifid, idex, exmem, memwb}
  localparam logic [2:0] FL_ALL  = 3'b111;
  localparam logic [2:0] FL_NONE = 3'b000;
  localparam logic [2:0] FL_LU   = 3'b010;    // {ifid, idex, exmem}

  logic        clk = 1'b0;
  logic        reset, start, idex_memread, ifid_use_rm, br_taken_mem, dmem_req, dmem_ready;
  logic [4:0]  idex_rd, ifid_rn, ifid_rm;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic [31:0] stall_cnt, flush_cnt;
  logic        mem_timeout;
  logic [1:0]  state_o;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .ifid_rn      (ifid_rn),
    .ifid_rm      (ifid_rm),
    .ifid_use_rm  (ifid_use_rm),
    .br_taken_mem (br_taken_mem),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .mem_timeout  (mem_timeout),
    .state_o      (state_o)
  );

  typedef struct {
    string       name;
    logic [4:0]  en;
    logic [2:0]  fl;
    logic [1:0]  st;
    logic [31:0] sc;
    logic [31:0] fc;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [4:0] act_en;
  logic [2:0] act_fl;
  assign act_en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  assign act_fl = {ifid_flush, idex_flush, exmem_flush};

  // Monitor: the DUT presents a new output set every cycle the driver issued one.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if (act_en === e.en && act_fl === e.fl && state_o === e.st && stall_cnt === e.sc &&
          flush_cnt === e.fc && mem_timeout === e.to) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got en=%b fl=%b st=%0d sc=%0d fc=%0d to=%b, want en=%b fl=%b st=%0d sc=%0d fc=%0d to=%b",
                 e.name, act_en, act_fl, state_o, stall_cnt, flush_cnt, mem_timeout,
                 e.en, e.fl, e.st, e.sc, e.fc, e.to);
      end
    end
  end

  task automatic clear_in();
    start        = 1'b0;
    idex_memread = 1'b0;
    idex_rd      = 5'd0;
    ifid_rn      = 5'd0;
    ifid_rm      = 5'd0;
    ifid_use_rm  = 1'b0;
    br_taken_mem = 1'b0;
    dmem_req     = 1'b0;
    dmem_ready   = 1'b0;
  endtask

  task automatic push(input string nm, input logic [4:0] en, input logic [2:0] fl,
                      input logic [1:0] st, input int unsigned sc, input int unsigned fc,
                      input logic to);
    exp_t e;
    e.name = nm;
    e.en   = en;
    e.fl   = fl;
    e.st   = st;
    e.sc   = sc;
    e.fc   = fc;
    e.to   = to;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // IDLE holds the pipe cleared until start
    push("idle_hold", EN_NONE, FL_ALL, 2'd0, 0, 0, 1'b0); tick();
    push("idle_hold2", EN_NONE, FL_ALL, 2'd0, 0, 0, 1'b0); tick();
    start = 1'b1;
    push("idle_start", EN_NONE, FL_ALL, 2'd0, 0, 0, 1'b0); tick();
    start = 1'b0;
    push("run_plain", EN_ALL, FL_NONE, 2'd1, 0, 0, 1'b0); tick();

    // Load-use on Rn, one bubble
    idex_memread = 1'b1; idex_rd = 5'd3; ifid_rn = 5'd3;
    push("load_use_rn", EN_LU, FL_LU, 2'd1, 0, 0, 1'b0); tick();
    clear_in();
    push("lu_cleared", EN_ALL, FL_NONE, 2'd1, 1, 0, 1'b0); tick();

    // XZR destination never stalls
    idex_memread = 1'b1; idex_rd = 5'd31; ifid_rn = 5'd31; ifid_rm = 5'd31; ifid_use_rm = 1'b1;
    push("xzr_no_stall", EN_ALL, FL_NONE, 2'd1, 1, 0, 1'b0); tick();

    // Rm match only counts when Rm is actually read
    clear_in();
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_rn = 5'd6; ifid_rm = 5'd5; ifid_use_rm = 1'b1;
    push("load_use_rm", EN_LU, FL_LU, 2'd1, 1, 0, 1'b0); tick();
    ifid_use_rm = 1'b0;
    push("rm_unused", EN_ALL, FL_NONE, 2'd1, 2, 0, 1'b0); tick();

    // Taken branch beats a simultaneous load-use
    clear_in();
    br_taken_mem = 1'b1; idex_memread = 1'b1; idex_rd = 5'd3; ifid_rn = 5'd3;
    push("br_over_lu", EN_ALL, FL_ALL, 2'd1, 2, 0, 1'b0); tick();
    clear_in();
    push("after_br", EN_ALL, FL_NONE, 2'd1, 2, 1, 1'b0); tick();
    start = 1'b1;
    push("start_ignored", EN_ALL, FL_NONE, 2'd1, 2, 1, 1'b0); tick();
    start = 1'b0;

    // Three-cycle memory wait
    dmem_req = 1'b1;
    push("mw_enter", EN_NONE, FL_NONE, 2'd1, 2, 1, 1'b0); tick();
    push("mw_wait1", EN_NONE, FL_NONE, 2'd2, 3, 1, 1'b0); tick();
    push("mw_wait2", EN_NONE, FL_NONE, 2'd2, 4, 1, 1'b0); tick();
    dmem_ready = 1'b1;
    push("mw_release", EN_ALL, FL_NONE, 2'd2, 5, 1, 1'b0); tick();
    clear_in();
    push("mw_after", EN_ALL, FL_NONE, 2'd1, 5, 1, 1'b0); tick();

    // Branch frozen behind a two-cycle wait is flushed only on release
    dmem_req = 1'b1; br_taken_mem = 1'b1;
    push("brw_enter", EN_NONE, FL_NONE, 2'd1, 5, 1, 1'b0); tick();
    push("brw_wait", EN_NONE, FL_NONE, 2'd2, 6, 1, 1'b0); tick();
    dmem_ready = 1'b1;
    push("brw_release", EN_ALL, FL_ALL, 2'd2, 7, 1, 1'b0); tick();
    clear_in();
    push("brw_after", EN_ALL, FL_NONE, 2'd1, 7, 2, 1'b0); tick();

    // Twenty-cycle wait: wait_cnt reaches 15 at the end of wait cycle 15
    dmem_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      push($sformatf("to_wait%0d", k), EN_NONE, FL_NONE, (k == 1) ? 2'd1 : 2'd2,
           7 + k - 1, 2, (k >= 16) ? 1'b1 : 1'b0);
      tick();
    end
    dmem_ready = 1'b1;
    push("to_release", EN_ALL, FL_NONE, 2'd2, 27, 2, 1'b1); tick();
    clear_in();
    push("to_sticky", EN_ALL, FL_NONE, 2'd1, 27, 2, 1'b1); tick();

    // Reset in the middle of a memory stall
    dmem_req = 1'b1;
    push("rst_enter", EN_NONE, FL_NONE, 2'd1, 27, 2, 1'b1); tick();
    reset = 1'b1;
    push("rst_in_wait", EN_NONE, FL_NONE, 2'd2, 28, 2, 1'b1); tick();
    reset = 1'b0;
    clear_in();
    push("rst_idle", EN_NONE, FL_ALL, 2'd0, 0, 0, 1'b0); tick();

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
